// File: rtl/ioctl_word_packer.sv
// Packs the ioctl download byte stream into 32-bit words with byte enables, queued through a first-word-fall-through FIFO.
// A completing byte appears on out_valid one cycle after it is accepted; ioctl_wait stalls upstream at DEPTH-1 words or while draining.

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_vld,
   input  logic [WIDTH-1:0]           wr_dat,
   output logic                       rd_vld,
   input  logic                       rd_rdy,
   output logic [WIDTH-1:0]           rd_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign rd_vld = (count != '0);
   assign pop    = rd_vld & rd_rdy;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign drop   = wr_vld & (count == FULL) & ~pop;
   assign push   = wr_vld & ~drop;
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module ioctl_word_packer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [22:0] out_addr,
   output logic [31:0] out_data,
   output logic [3:0]  out_be,
   output logic        done,
   output logic        overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] WAIT_LVL = (AW+1)'(DEPTH-1);

   typedef struct packed {
      logic [22:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } word_t;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t      state;
   word_t       acc;
   word_t       acc_nxt;
   word_t       merged;
   word_t       fresh;
   word_t       push_dat;
   word_t       head;
   logic        push_vld;
   logic        accept;
   logic        flush;
   logic        same_word;
   logic [3:0]  lane_be;
   logic [22:0] waddr;
   logic [AW:0] fifo_cnt;
   logic        fifo_drop;

   assign waddr     = ioctl_addr[24:2];
   assign lane_be   = 4'b0001 << ioctl_addr[1:0];
   assign accept    = (state == LOAD) & ioctl_download & ioctl_wr;
   assign flush     = (state == LOAD) & ~ioctl_download & (acc.be != 4'h0);
   assign same_word = (acc.be == 4'h0) | (acc.addr == waddr);

   always_comb begin
      merged      = acc;
      merged.addr = waddr;
      merged.be   = acc.be | lane_be;
      for (int n = 0; n < 4; n++) begin
         if (ioctl_addr[1:0] == 2'(n)) begin
            merged.data[8*n +: 8] = ioctl_dout;
         end
      end

      fresh.addr = waddr;
      fresh.data = 32'(ioctl_dout) << {ioctl_addr[1:0], 3'b000};
      fresh.be   = lane_be;

      push_vld = 1'b0;
      push_dat = acc;
      acc_nxt  = acc;
      if (accept) begin
         if (same_word) begin
            if (merged.be == 4'hF) begin
               push_vld = 1'b1;
               push_dat = merged;
               acc_nxt  = '0;
            end else begin
               acc_nxt = merged;
            end
         end else begin
            // Address moved on: retire the partial word and start over with this byte.
            push_vld = 1'b1;
            push_dat = acc;
            acc_nxt  = fresh;
         end
      end else if (flush) begin
         push_vld = 1'b1;
         push_dat = acc;
         acc_nxt  = '0;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (push_vld),
      .wr_dat (push_dat),
      .rd_vld (out_valid),
      .rd_rdy (out_ready),
      .rd_dat (head),
      .count  (fifo_cnt),
      .drop   (fifo_drop)
   );

   assign out_addr   = head.addr;
   assign out_data   = head.data;
   assign out_be     = head.be;
   assign ioctl_wait = (fifo_cnt >= WAIT_LVL) | (state == DRAIN) | (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         acc  <= acc_nxt;
         done <= 1'b0;
         if (fifo_drop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (ioctl_download) begin
                  state    <= LOAD;
                  overflow <= 1'b0;
               end
            end
            LOAD: begin
               if (!ioctl_download) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_cnt == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ioctl_word_packer.sv
// Directed bench for ioctl_word_packer: single-word, partial-word flush, backpressure, overflow, toggled ready and reset mid-download.
module tb_ioctl_word_packer;
   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        out_valid;
   logic        out_ready;
   logic [22:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        done;
   logic        overflow;

   int vectors = 0;
   int miscompares = 0;

   ioctl_word_packer #(.DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_addr       (out_addr),
      .out_data       (out_data),
      .out_be         (out_be),
      .done           (done),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic count_done(input int max, output int pulses);
      pulses = 0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (done) pulses++;
      end
   endtask

   function automatic logic [7:0] e_byte(input int c);
      return 8'(c * 7 + 3);
   endfunction

   function automatic logic [31:0] e_word(input int k);
      return {e_byte(4*k+3), e_byte(4*k+2), e_byte(4*k+1), e_byte(4*k)};
   endfunction

   task automatic run_basic(input string pfx);
      int p;
      out_ready      = 1'b1;
      ioctl_download = 1'b1;
      tick();
      wr_byte(25'h0, 8'h11);
      wr_byte(25'h1, 8'h22);
      wr_byte(25'h2, 8'h33);
      chk({pfx, "_no_early_valid"}, out_valid, 0);
      wr_byte(25'h3, 8'h44);
      chk({pfx, "_valid"}, out_valid, 1);
      chk({pfx, "_addr"}, out_addr, 23'h0);
      chk({pfx, "_data"}, out_data, 32'h44332211);
      chk({pfx, "_be"}, out_be, 4'hF);
      ioctl_download = 1'b0;
      tick();
      chk({pfx, "_popped"}, out_valid, 0);
      chk({pfx, "_wait_drain"}, ioctl_wait, 1);
      count_done(6, p);
      chk({pfx, "_done_once"}, p, 1);
      chk({pfx, "_wait_idle"}, ioctl_wait, 0);
   endtask

   initial begin
      int p;
      int pops;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      out_ready      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_be", out_be, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_data", out_data, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_wait", ioctl_wait, 0);

      // Single full word.
      run_basic("a");

      // Address change retires a partial word; end of download flushes the last one.
      out_ready      = 1'b0;
      ioctl_download = 1'b1;
      tick();
      wr_byte(25'h10, 8'hAA);
      wr_byte(25'h11, 8'hBB);
      chk("b_partial_held", out_valid, 0);
      wr_byte(25'h20, 8'hCC);
      chk("b_valid", out_valid, 1);
      chk("b_addr", out_addr, 23'h4);
      chk("b_data", out_data, 32'h0000BBAA);
      chk("b_be", out_be, 4'h3);
      ioctl_download = 1'b0;
      tick();
      chk("b_head_kept", out_addr, 23'h4);
      out_ready = 1'b1;
      tick();
      chk("b_flush_valid", out_valid, 1);
      chk("b_flush_addr", out_addr, 23'h8);
      chk("b_flush_data", out_data, 32'h000000CC);
      chk("b_flush_be", out_be, 4'h1);
      count_done(8, p);
      chk("b_done_once", p, 1);
      chk("b_ovf", overflow, 0);

      // Backpressure honoured: wait rises at three queued words.
      out_ready      = 1'b0;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) wr_byte(25'h100 + 25'(i), 8'(i + 1));
      chk("c_wait_at3", ioctl_wait, 1);
      chk("c_ovf", overflow, 0);
      chk("c_head0_addr", out_addr, 23'h40);
      chk("c_head0_data", out_data, 32'h04030201);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("c_wait_at2", ioctl_wait, 0);
      for (int i = 12; i < 16; i++) wr_byte(25'h100 + 25'(i), 8'(i + 1));
      chk("c_wait_again", ioctl_wait, 1);
      ioctl_download = 1'b0;
      tick();
      out_ready = 1'b1;
      for (int w = 1; w < 4; w++) begin
         chk("c_order_valid", out_valid, 1);
         chk("c_order_addr", out_addr, 23'h40 + 23'(w));
         chk("c_order_data", out_data, {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
         tick();
      end
      count_done(6, p);
      chk("c_done_once", p, 1);
      chk("c_ovf_end", overflow, 0);

      // Ignoring wait: fifth word is dropped and overflow sticks until the next download.
      out_ready      = 1'b0;
      ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) wr_byte(25'h200 + 25'(i), 8'(8'h20 + i));
      chk("d_ovf_set", overflow, 1);
      ioctl_download = 1'b0;
      tick();
      chk("d_ovf_sticky", overflow, 1);
      out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         chk("d_addr", out_addr, 23'h80 + 23'(w));
         chk("d_data", out_data, {8'(8'h23 + 4*w), 8'(8'h22 + 4*w), 8'(8'h21 + 4*w), 8'(8'h20 + 4*w)});
         tick();
      end
      count_done(6, p);
      chk("d_done_once", p, 1);
      chk("d_ovf_after_done", overflow, 1);
      ioctl_download = 1'b1;
      tick();
      chk("d_ovf_cleared", overflow, 0);
      ioctl_download = 1'b0;
      count_done(6, p);
      chk("d_empty_done", p, 1);

      // Ready toggles every cycle while bytes stream at one per cycle.
      pops = 0;
      ioctl_download = 1'b1;
      tick();
      for (int c = 0; c < 32; c++) begin
         out_ready = (c % 2 == 1);
         if (out_valid && out_ready) begin
            chk("e_addr", out_addr, 23'h100 + 23'(pops));
            chk("e_data", out_data, e_word(pops));
            pops++;
         end
         wr_byte(25'h400 + 25'(c), e_byte(c));
      end
      ioctl_download = 1'b0;
      p = 0;
      for (int c = 0; c < 40; c++) begin
         out_ready = (c % 2 == 1);
         if (out_valid && out_ready) begin
            chk("e_addr", out_addr, 23'h100 + 23'(pops));
            chk("e_data", out_data, e_word(pops));
            pops++;
         end
         tick();
         if (done) p++;
      end
      chk("e_pops", pops, 8);
      chk("e_done_once", p, 1);
      chk("e_ovf", overflow, 0);

      // Reset in the middle of a word discards it without a done pulse.
      out_ready      = 1'b1;
      ioctl_download = 1'b1;
      tick();
      wr_byte(25'h0, 8'h55);
      wr_byte(25'h1, 8'h66);
      reset = 1'b1;
      tick();
      chk("f_rst_valid", out_valid, 0);
      chk("f_rst_done", done, 0);
      chk("f_rst_wait", ioctl_wait, 0);
      reset          = 1'b0;
      ioctl_download = 1'b0;
      p    = 0;
      pops = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done) p++;
         if (out_valid) pops++;
      end
      chk("f_no_done", p, 0);
      chk("f_no_valid", pops, 0);
      run_basic("f");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ioctl_word_packer.md
IOCTL_WORD_PACKER -- requirements
Module: ioctl_word_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning output FIFO depth in 32-bit words (power of two, >= 2).
REQ-002 The block SHALL have port clk  input  1  the single clock for all logic.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port ioctl_download  input  1  high for the duration of a ROM download.
REQ-005 The block SHALL have port ioctl_wr  input  1  byte write strobe, one byte per cycle.
REQ-006 The block SHALL have port ioctl_addr  input  25  byte address of ioctl_dout.
REQ-007 The block SHALL have port ioctl_dout  input  8  download byte.
REQ-008 The block SHALL have port ioctl_wait  output  1  upstream stall request.
REQ-009 The block SHALL have port out_valid  output  1  FIFO head word valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts head word.
REQ-011 The block SHALL have port out_addr  output  23  word address (ioctl_addr[24:2]) of the head word.
REQ-012 The block SHALL have port out_data  output  32  head word data.
REQ-013 The block SHALL have port out_be  output  4  head word byte enables.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse when a download is fully drained.
REQ-015 The block SHALL have port overflow  output  1  sticky error: FIFO push dropped.

Function
REQ-016 Byte lane SHALL be ioctl_addr[1:0]; lane n maps to data[8n+7:8n] and be[n] (little-endian).
REQ-017 State machine SHALL have states IDLE, LOAD, DRAIN, DONE; all transitions on clk.
REQ-018 IDLE -> LOAD when ioctl_download=1; entering LOAD clears overflow.
REQ-019 LOAD -> DRAIN when ioctl_download=0; DRAIN -> DONE when FIFO empty; DONE -> IDLE unconditionally after one cycle.
REQ-020 done SHALL be 1 only in DONE (exactly one cycle).
REQ-021 ioctl_wr SHALL be accepted only in LOAD with ioctl_download=1; otherwise ignored.
REQ-022 Accepted byte, same word as accumulator (or accumulator empty): byte stored in its lane, be[lane] set; a rewrite of a set lane overwrites.
REQ-023 When an accepted byte makes accumulator be=4'hF, the word SHALL be pushed that cycle-edge and the accumulator cleared.
REQ-024 Accepted byte with word address differing from a non-empty accumulator: accumulator (partial be) SHALL be pushed, and accumulator reloaded with only the new byte.
REQ-025 At most one push per cycle; a single byte never completes a word, so REQ-023 and REQ-024 never coincide.
REQ-026 On LOAD -> DRAIN, a non-empty accumulator SHALL be pushed as a partial word in the same transition.
REQ-027 FIFO SHALL be first-word-fall-through: out_valid=1 iff count>0; out_addr/out_data/out_be show head; pop when out_valid & out_ready.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH.
REQ-029 ioctl_wait SHALL be combinational: 1 iff count >= DEPTH-1, or state is DRAIN or DONE.
REQ-030 Push at count=DEPTH without same-cycle pop SHALL be dropped and set overflow; FIFO contents unaffected.
REQ-031 Accept-to-out_valid latency SHALL be 1 cycle for a completing byte into an empty FIFO.
REQ-032 Data SHALL leave in push order; FIFO pointers wrap modulo DEPTH.

Reset
REQ-033 reset=1 SHALL force IDLE, count=0, accumulator be=0, out_valid=0, out_be=0, out_addr=0, out_data=0, done=0, overflow=0, ioctl_wait=0 on the next edge.
REQ-034 reset mid-download SHALL discard accumulator and FIFO contents with no push and no done pulse.

Verification
REQ-035 Download bytes 11,22,33,44 at addr 0..3, out_ready=1 -> one word addr 0, data 0x44332211, be F, out_valid one cycle after 4th byte; then done pulse once.
REQ-036 Bytes AA@0x10, BB@0x11, then CC@0x20 -> word addr 0x4 data 0x0000BBAA be 3; CC flushed on download end as addr 0x8 data 0x000000CC be 1.
REQ-037 DEPTH=4, out_ready=0, 16 contiguous bytes honoring ioctl_wait -> ioctl_wait=1 at count 3, no overflow; release out_ready -> 4 words in order, done after last pop.
REQ-038 Writes ignoring ioctl_wait with out_ready=0 -> 5th push dropped, overflow=1 until next LOAD entry; first 4 words intact.
REQ-039 out_ready toggled every cycle during steady 1-byte/cycle load -> no loss, no duplicate, count never exceeds DEPTH.
REQ-040 reset asserted after 2 bytes of a word -> out_valid stays 0, no done; new download afterwards behaves as REQ-035.
